dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer in front of data_mem. Port 0 is the core
//  load/store path; port 1 is the loader/debug path. Grants one access at a time, drives
//  the data_mem control/address/data inputs from registers, and returns load data with
//  rvalid. Misaligned SH/SW/LH/LHU/LW are rejected with an err pulse; memory is not touched.
// PARAMETERS
//  INIT_LAST  1  Port treated as last-granted after reset (1 => port 0 wins the first tie).
// PORTS
//  clk            in   1   Clock; all logic on posedge.
//  rst            in   1   Synchronous, active-high reset.
//  req[1:0]       in   2   Per-port request; held with fields stable until gnt or err.
//  alucode0/1     in   6   Per-port access type (`ALU_LB..`ALU_LW, `ALU_SB/SH/SW).
//  addr0/1        in   32  Per-port byte address.
//  wdata0/1       in   32  Per-port store data.
//  gnt[1:0]       out  2   One-cycle pulse: port's access is issued to memory this cycle.
//  rvalid[1:0]    out  2   One-cycle pulse: rdata holds load result for that port.
//  err[1:0]       out  2   One-cycle pulse: port's request rejected (misaligned or non-mem alucode).
//  rdata          out  32  Load result; equals mem_data_r; meaningful only when rvalid!=0.
//  mem_alucode    out  6   To data_mem alucode.
//  mem_is_load    out  1   To data_mem is_load.
//  mem_is_store   out  1   To data_mem is_store.
//  mem_addr_w     out  32  To data_mem addr_w (always equal to mem_addr_r).
//  mem_addr_r     out  32  To data_mem addr_r.
//  mem_data_w     out  32  To data_mem data_w.
//  mem_data_r     in   32  From data_mem data_r (registered in data_mem, 1-cycle latency).
// BEHAVIOUR
//  - Reset: state=IDLE, last=INIT_LAST, gnt/rvalid/err=0, mem_is_load/store=0,
//    mem_alucode/addr/data_w=0. rdata is combinational from mem_data_r.
//  - FSM states IDLE, ISSUE, RESP.
//  - IDLE: if req!=0, pick winner w: single requester wins; both => port != last.
//    Check legality: SH/LH/LHU need addr[0]==0; SW/LW need addr[1:0]==0; alucode must be
//    a load/store code. Illegal: err[w]<=1 next cycle, last<=w, stay IDLE.
//    Legal: register alucode/addr/wdata into mem_* outputs, set mem_is_load or
//    mem_is_store, gnt[w]<=1, last<=w, go ISSUE.
//  - ISSUE (1 cycle): mem_* strobes high; data_mem acts at the closing edge. Next:
//    strobes<=0, gnt<=0; load => RESP, store => IDLE.
//  - RESP (1 cycle): rvalid[w]=1, rdata=mem_data_r. Next: IDLE.
//  - Latency from req seen in IDLE: gnt at +1, store written at +1 edge, rvalid at +2.
//    Throughput: store every 2 cycles, load every 3. New arbitration only in IDLE.
//  - Requester deasserts req the cycle after seeing gnt or err; a req still high in
//    IDLE is treated as a new request.
//  - mem_addr_w and mem_addr_r both driven with the granted address (data_mem uses
//    addr_w[1:0] as byte lane select for loads).
//  - Only one of gnt/rvalid/err bits is ever set in any cycle; never for both ports.
//  - Reset in ISSUE: strobes were high during that cycle, so the access completes in
//    memory; no rvalid is produced. Reset in RESP: rvalid suppressed.
//  - Fairness: with both req held high continuously, grants alternate 0,1,0,1...
// TESTING
//  1 Port 0 SW addr=0x100 wdata=0xDEADBEEF, then LW addr=0x100 -> gnt[0] at +1 each,
//    rvalid[0] at +2 of the load, rdata=0xDEADBEEF.
//  2 Both ports LW after reset, INIT_LAST=1 -> gnt order 0,1,0,1 over four requests,
//    no cycle with two gnt bits set.
//  3 Port 1 SB addr=0x103 data=0x80, then LB 0x103 -> rdata=0xFFFFFF80; LBU -> 0x00000080.
//  4 Port 0 SW addr=0x102 -> err[0] at +1, no gnt, mem_is_store never high; memory
//    word 0x100 unchanged on later LW.
//  5 rst asserted during RESP of a port-1 load -> rvalid stays 0, state IDLE, all outputs
//    at reset values next cycle; next request arbitrates with port 0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of data_mem: one access in flight,
// registered memory controls, misaligned or non-memory requests rejected with an err pulse.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter logic INIT_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [5:0]  alucode0,
  input  logic [5:0]  alucode1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic [5:0]  mem_alucode,
  output logic        mem_is_load,
  output logic        mem_is_store,
  output logic [31:0] mem_addr_w,
  output logic [31:0] mem_addr_r,
  output logic [31:0] mem_data_w,
  input  logic [31:0] mem_data_r
);

  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]  state;
  logic        last;
  logic        owner;
  logic [31:0] mem_addr;

  logic [1:0]  cand;
  logic        win;
  logic [5:0]  sel_code;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_load;
  logic        sel_store;
  logic        sel_half;
  logic        sel_word;
  logic        sel_legal;

  // A port whose err pulse is showing this cycle still holds req for the rejected
  // access; masking it keeps one rejection from being reported twice.
  always_comb begin
    cand = req & ~err;
    win  = 1'b0;
    if (cand == 2'b10)      win = 1'b1;
    else if (cand == 2'b11) win = ~last;
    sel_code  = win ? alucode1 : alucode0;
    sel_addr  = win ? addr1    : addr0;
    sel_wdata = win ? wdata1   : wdata0;
    sel_load  = (sel_code == ALU_LB) || (sel_code == ALU_LH) || (sel_code == ALU_LW) ||
                (sel_code == ALU_LBU) || (sel_code == ALU_LHU);
    sel_store = (sel_code == ALU_SB) || (sel_code == ALU_SH) || (sel_code == ALU_SW);
    sel_half  = (sel_code == ALU_LH) || (sel_code == ALU_LHU) || (sel_code == ALU_SH);
    sel_word  = (sel_code == ALU_LW) || (sel_code == ALU_SW);
    sel_legal = (sel_load || sel_store) &&
                !(sel_half && sel_addr[0]) &&
                !(sel_word && (sel_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      last         <= INIT_LAST;
      owner        <= 1'b0;
      gnt          <= 2'b00;
      err          <= 2'b00;
      mem_alucode  <= 6'd0;
      mem_is_load  <= 1'b0;
      mem_is_store <= 1'b0;
      mem_addr     <= 32'd0;
      mem_data_w   <= 32'd0;
    end else begin
      gnt <= 2'b00;
      err <= 2'b00;
      case (state)
        S_IDLE: begin
          if (cand != 2'b00) begin
            last  <= win;
            owner <= win;
            if (sel_legal) begin
              mem_alucode  <= sel_code;
              mem_addr     <= sel_addr;
              mem_data_w   <= sel_wdata;
              mem_is_load  <= sel_load;
              mem_is_store <= sel_store;
              gnt          <= win ? 2'b10 : 2'b01;
              state        <= S_ISSUE;
            end else begin
              err <= win ? 2'b10 : 2'b01;
            end
          end
        end
        S_ISSUE: begin
          mem_is_load  <= 1'b0;
          mem_is_store <= 1'b0;
          state        <= mem_is_load ? S_RESP : S_IDLE;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // data_mem registers its read at the close of ISSUE, so the word is on mem_data_r in RESP.
  assign rvalid     = ((state == S_RESP) && !rst) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rdata      = mem_data_r;
  assign mem_addr_w = mem_addr;
  assign mem_addr_r = mem_addr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data_mem, byte-array reference memory, per-port
// expected queues popped by a monitor on every gnt/err/rvalid pulse.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;
  localparam logic [5:0] ALU_BAD = 6'd3;

  localparam logic [1:0] K_ST  = 2'd0;
  localparam logic [1:0] K_LD  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  logic        clk, rst;
  logic        req0_v, req1_v;
  logic [1:0]  req;
  logic [5:0]  alucode0, alucode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata;
  logic [5:0]  mem_alucode;
  logic        mem_is_load, mem_is_store;
  logic [31:0] mem_addr_w, mem_addr_r, mem_data_w, mem_data_r;

  assign req = {req1_v, req0_v};

  int checks = 0;
  int errors = 0;

  // entry: [71:66] alucode, [65:64] kind, [63:32] addr, [31:0] data
  logic [71:0] exp_q0[$];
  logic [71:0] exp_q1[$];
  int          gnt_log[$];
  logic [7:0]  env_mem[4096];
  logic [7:0]  ref_mem[4096];
  logic        env_clear;
  logic        mon_pend = 1'b0;
  int          mon_port = 0;
  logic [31:0] mon_data = 32'd0;
  logic [31:0] last_rdata = 32'd0;
  int          store_cnt = 0;

  dmem_arbiter #(.INIT_LAST(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req),
    .alucode0(alucode0), .alucode1(alucode1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata),
    .mem_alucode(mem_alucode), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .mem_addr_w(mem_addr_w), .mem_addr_r(mem_addr_r), .mem_data_w(mem_data_w),
    .mem_data_r(mem_data_r)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int acc_size(input logic [5:0] c);
    case (c)
      ALU_LB, ALU_LBU, ALU_SB: return 1;
      ALU_LH, ALU_LHU, ALU_SH: return 2;
      ALU_LW, ALU_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_load_code(input logic [5:0] c);
    return (c == ALU_LB) || (c == ALU_LBU) || (c == ALU_LH) || (c == ALU_LHU) || (c == ALU_LW);
  endfunction

  function automatic logic [31:0] extract(input logic [5:0] c, input logic [31:0] w,
                                          input logic [1:0] lane);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (c)
      ALU_LB:  return {{24{s[7]}}, s[7:0]};
      ALU_LBU: return {24'd0, s[7:0]};
      ALU_LH:  return {{16{s[15]}}, s[15:0]};
      ALU_LHU: return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] env_word(input logic [31:0] a);
    return {env_mem[{a[11:2], 2'd3}], env_mem[{a[11:2], 2'd2}],
            env_mem[{a[11:2], 2'd1}], env_mem[{a[11:2], 2'd0}]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[{a[11:2], 2'd3}], ref_mem[{a[11:2], 2'd2}],
            ref_mem[{a[11:2], 2'd1}], ref_mem[{a[11:2], 2'd0}]};
  endfunction

  // behavioural data_mem: registered read, byte lanes from addr_w[1:0]
  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < 4096; i++) env_mem[i] <= 8'd0;
    end else begin
      if (mem_is_store)
        for (int i = 0; i < acc_size(mem_alucode); i++)
          env_mem[12'(mem_addr_w[11:0] + 12'(i))] <= mem_data_w[8*i +: 8];
      if (mem_is_load)
        mem_data_r <= extract(mem_alucode, env_word(mem_addr_r), mem_addr_w[1:0]);
    end
  end

  always @(negedge clk) if (mem_is_store) store_cnt++;

  // reference model: legality from access size, memory as a byte array
  task automatic expect_push(input int p, input logic [5:0] c, input logic [31:0] a,
                             input logic [31:0] d);
    logic [71:0] e;
    int sz;
    sz = acc_size(c);
    if (sz == 0 || (a % sz) != 0) begin
      e = {c, K_ERR, a, 32'd0};
    end else if (is_load_code(c)) begin
      e = {c, K_LD, a, extract(c, ref_word(a), a[1:0])};
    end else begin
      for (int i = 0; i < sz; i++) ref_mem[12'(a[11:0] + 12'(i))] = d[8*i +: 8];
      e = {c, K_ST, a, d};
    end
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // driver: called and returns at posedge+1; holds req until gnt/err, then drops it a cycle
  task automatic issue(input int p, input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    bit seen;
    expect_push(p, c, a, d);
    if (p == 0) begin req0_v = 1'b1; alucode0 = c; addr0 = a; wdata0 = d; end
    else        begin req1_v = 1'b1; alucode1 = c; addr1 = a; wdata1 = d; end
    seen = 1'b0;
    lat  = -1;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (gnt[p] || err[p]) begin seen = 1'b1; lat = n - 1; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout port %0d: no gnt/err after 40 cycles, required one", p);
    end
    @(posedge clk); #1;
    if (p == 0) req0_v = 1'b0;
    else        req1_v = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [71:0] e;
    bit have;
    if (rst) begin
      mon_pend = 1'b0;
    end else begin
      if ({gnt, rvalid, err} != 6'd0) begin
        checks++;
        if (!$onehot({gnt, rvalid, err})) begin
          errors++;
          $display("FAIL onehot: gnt=%b rvalid=%b err=%b", gnt, rvalid, err);
        end
      end
      if (mon_pend) begin
        checks++;
        if (rvalid !== (2'b01 << mon_port) || rdata !== mon_data) begin
          errors++;
          $display("FAIL load_resp port %0d: rvalid=%b rdata=%h required rdata=%h",
                   mon_port, rvalid, rdata, mon_data);
        end
        last_rdata = rdata;
        mon_pend   = 1'b0;
      end else if (rvalid != 2'b00) begin
        checks++;
        errors++;
        $display("FAIL stray_rvalid: rvalid=%b required 00", rvalid);
      end
      for (int p = 0; p < 2; p++) begin
        if (gnt[p] || err[p]) begin
          have = 1'b0;
          e    = '0;
          if (p == 0 && exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
          if (p == 1 && exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected port %0d: gnt=%b err=%b with empty queue", p, gnt, err);
          end else if (err[p]) begin
            if (e[65:64] != K_ERR || mem_is_load || mem_is_store) begin
              errors++;
              $display("FAIL err_kind port %0d: got err strobes=%b%b required kind %0d",
                       p, mem_is_load, mem_is_store, e[65:64]);
            end
          end else begin
            gnt_log.push_back(p);
            if ({mem_alucode, mem_is_load, mem_is_store, mem_addr_r, mem_addr_w} !==
                {e[71:66], e[65:64] == K_LD, e[65:64] == K_ST, e[63:32], e[63:32]}) begin
              errors++;
              $display("FAIL issue port %0d: got code=%0d ld=%b st=%b ar=%h aw=%h required code=%0d kind=%0d addr=%h",
                       p, mem_alucode, mem_is_load, mem_is_store, mem_addr_r, mem_addr_w,
                       e[71:66], e[65:64], e[63:32]);
            end
            if (e[65:64] == K_ST && mem_data_w !== e[31:0]) begin
              errors++;
              $display("FAIL store_data port %0d: got %h required %h", p, mem_data_w, e[31:0]);
            end
            if (e[65:64] == K_LD) begin
              mon_pend = 1'b1;
              mon_port = p;
              mon_data = e[31:0];
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int lat, lat1, sc;
    logic [5:0] codes [9];
    codes[0] = ALU_LB; codes[1] = ALU_LH; codes[2] = ALU_LW; codes[3] = ALU_LBU;
    codes[4] = ALU_LHU; codes[5] = ALU_SB; codes[6] = ALU_SH; codes[7] = ALU_SW;
    codes[8] = ALU_BAD;
    rst = 1'b1; env_clear = 1'b1;
    req0_v = 1'b0; req1_v = 1'b0;
    alucode0 = 6'd0; alucode1 = 6'd0; addr0 = 32'd0; addr1 = 32'd0;
    wdata0 = 32'd0; wdata1 = 32'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_pulses", {26'd0, gnt, rvalid, err}, 32'd0);
    check_val("reset_mem_ctrl", {24'd0, mem_alucode, mem_is_load, mem_is_store}, 32'd0);
    check_val("reset_addr", mem_addr_r | mem_addr_w, 32'd0);
    check_val("reset_wdata", mem_data_w, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; env_clear = 1'b0;

    // store then load on port 0
    issue(0, ALU_SW, 32'h100, 32'hDEADBEEF, lat);
    check_val("sw_gnt_latency", lat, 1);
    issue(0, ALU_LW, 32'h100, 32'h0, lat);
    check_val("lw_gnt_latency", lat, 1);
    check_val("lw_rdata", last_rdata, 32'hDEADBEEF);

    // fairness from reset
    do_reset();
    gnt_log.delete();
    fork
      begin issue(0, ALU_LW, 32'h100, 32'h0, lat); issue(0, ALU_LW, 32'h100, 32'h0, lat); end
      begin issue(1, ALU_LW, 32'h104, 32'h0, lat1); issue(1, ALU_LW, 32'h104, 32'h0, lat1); end
    join
    check_val("rr_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4)
      check_val("rr_order", {gnt_log[0][7:0], gnt_log[1][7:0], gnt_log[2][7:0], gnt_log[3][7:0]},
                32'h00010001);

    // byte store and sign/zero extended byte loads on port 1
    issue(1, ALU_SB, 32'h103, 32'h80, lat);
    issue(1, ALU_LB, 32'h103, 32'h0, lat);
    check_val("lb_rdata", last_rdata, 32'hFFFFFF80);
    issue(1, ALU_LBU, 32'h103, 32'h0, lat);
    check_val("lbu_rdata", last_rdata, 32'h00000080);

    // misaligned store is rejected and leaves memory alone
    sc = store_cnt;
    issue(0, ALU_SW, 32'h102, 32'h12345678, lat);
    check_val("err_latency", lat, 1);
    check_val("err_no_store", store_cnt, sc);
    issue(0, ALU_LW, 32'h100, 32'h0, lat);
    check_val("word_unchanged", last_rdata, 32'h80ADBEEF);

    // reset during RESP of a port-1 load
    expect_push(1, ALU_LW, 32'h104, 32'h0);
    req1_v = 1'b1; alucode1 = ALU_LW; addr1 = 32'h104;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (gnt[1]) lat = n - 1;
    end
    check_val("rst_load_gnt_latency", lat, 1);
    @(posedge clk); #1;
    rst = 1'b1; req1_v = 1'b0;
    @(negedge clk);
    check_val("rst_rvalid_suppressed", {30'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_pulses", {26'd0, gnt, rvalid, err}, 32'd0);
    check_val("post_rst_mem_ctrl", {24'd0, mem_alucode, mem_is_load, mem_is_store}, 32'd0);
    check_val("post_rst_addr_data", mem_addr_r | mem_addr_w | mem_data_w, 32'd0);
    @(posedge clk); #1;
    gnt_log.delete();
    fork
      issue(0, ALU_LW, 32'h100, 32'h0, lat);
      issue(1, ALU_LW, 32'h104, 32'h0, lat1);
    join
    check_val("post_rst_first_latency", lat, 1);
    if (gnt_log.size() == 2)
      check_val("post_rst_order", {gnt_log[0][7:0], gnt_log[1][7:0]}, 32'h0001);
    else
      check_val("post_rst_count", gnt_log.size(), 2);

    // randomized concurrent traffic, disjoint address windows per port
    fork
      for (int k = 0; k < 60; k++) begin
        int l0;
        issue(0, codes[$urandom_range(0, 8)], 32'h200 + $urandom_range(0, 255), $urandom, l0);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int k = 0; k < 60; k++) begin
        int l1;
        issue(1, codes[$urandom_range(0, 8)], 32'h400 + $urandom_range(0, 255), $urandom, l1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    join

    repeat (4) @(posedge clk);
    check_val("queues_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
